// File: rtl/ualink_cmd_filter.sv
// Command filter in front of ualink_turbo64: buffers the 5-word header, forwards matching
// UDP read/write commands to the egress stream and drops everything else.
module ualink_cmd_filter #(
  parameter logic [15:0] UDP_PORT = 16'h3039,
  parameter logic [7:0]  OP_RD    = 8'h01,
  parameter logic [7:0]  OP_WR    = 8'h02
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [63:0]  s_axis_tdata,
  input  logic [7:0]   s_axis_tstrb,
  input  logic [127:0] s_axis_tuser,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [63:0]  m_axis_tdata,
  output logic [7:0]   m_axis_tstrb,
  output logic [127:0] m_axis_tuser,
  output logic         m_axis_tvalid,
  output logic         m_axis_tlast,
  input  logic         m_axis_tready,
  output logic [7:0]   cmd_opcode,
  output logic [15:0]  pkt_pass_cnt,
  output logic [15:0]  pkt_drop_cnt
);

  typedef enum logic [1:0] {StHdr, StFwdHdr, StFwdBody, StDrop} state_e;

  state_e       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   opcode_q, opcode_d;
  logic [15:0]  pass_cnt_q, drop_cnt_q;
  logic [127:0] tuser_q;
  logic [63:0]  buf_data_q [5];
  logic [7:0]   buf_strb_q [5];
  logic         cap_en, pass_inc, drop_inc, hdr_match;
  logic [7:0]   tos;

  assign tos = buf_data_q[1][63:56];

  // Evaluated while word 4 is on the input; the destination port is still on the bus.
  assign hdr_match = (buf_data_q[1][47:32] == 16'h0008) &&
                     (buf_data_q[2][63:56] == 8'h11) &&
                     ({s_axis_tdata[39:32], s_axis_tdata[47:40]} == UDP_PORT) &&
                     ((tos == OP_RD) || (tos == OP_WR));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    opcode_d      = opcode_q;
    cap_en        = 1'b0;
    pass_inc      = 1'b0;
    drop_inc      = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    case (state_q)
      StHdr: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          cap_en = 1'b1;
          if (s_axis_tlast) begin
            drop_inc = 1'b1;
            idx_d    = '0;
          end else if (idx_q == 3'd4) begin
            idx_d = '0;
            if (hdr_match) begin
              state_d  = StFwdHdr;
              opcode_d = tos;
            end else begin
              state_d = StDrop;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StFwdHdr: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = buf_data_q[idx_q];
        m_axis_tstrb  = buf_strb_q[idx_q];
        m_axis_tuser  = tuser_q;
        if (m_axis_tready) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = StFwdBody;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StFwdBody: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tstrb  = s_axis_tstrb;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = tuser_q;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pass_inc = 1'b1;
          state_d  = StHdr;
        end
      end
      StDrop: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          drop_inc = 1'b1;
          state_d  = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StHdr;
      idx_q      <= '0;
      opcode_q   <= '0;
      tuser_q    <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      opcode_q <= opcode_d;
      if (cap_en && (idx_q == 3'd0)) tuser_q <= s_axis_tuser;
      if (pass_inc && (pass_cnt_q != 16'hFFFF)) pass_cnt_q <= pass_cnt_q + 16'd1;
      if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  // Header buffer content is only observable in StFwdHdr, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap_en) begin
      buf_data_q[idx_q] <= s_axis_tdata;
      buf_strb_q[idx_q] <= s_axis_tstrb;
    end
  end

  assign cmd_opcode   = opcode_q;
  assign pkt_pass_cnt = pass_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ualink_cmd_filter.sv
// Bench for ualink_cmd_filter: byte-level packet model with an output scoreboard,
// plus directed scenarios with literal expectations.
module tb_ualink_cmd_filter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tlast = 1'b0;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic         m_axis_tready = 1'b1;
  logic [7:0]   cmd_opcode;
  logic [15:0]  pkt_pass_cnt, pkt_drop_cnt;

  always #5 clk = ~clk;

  ualink_cmd_filter dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .cmd_opcode(cmd_opcode), .pkt_pass_cnt(pkt_pass_cnt), .pkt_drop_cnt(pkt_drop_cnt)
  );

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] tuser;
    logic [7:0]   op;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] pd[$];
  logic [7:0]  ps[$];
  int          n_cmp = 0, n_fail = 0, out_cnt = 0, rdy_mode = 0, pkt_seq = 0;
  logic [15:0] m_pass = '0, m_drop = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] pbyte(input int k);
    logic [63:0] w;
    w = pd[k / 8];
    return w[8 * (k % 8) +: 8];
  endfunction

  // Acceptance rule from the packet bytes: EtherType 0x0800 at bytes 12-13, TOS byte 15,
  // protocol byte 23, big-endian UDP destination port at bytes 36-37, more than 5 words.
  function automatic bit model_pass();
    logic [7:0] t;
    if (pd.size() <= 5) return 1'b0;
    t = pbyte(15);
    return pbyte(12) == 8'h08 && pbyte(13) == 8'h00 && pbyte(23) == 8'h11 &&
           {pbyte(36), pbyte(37)} == 16'h3039 && (t == 8'h01 || t == 8'h02);
  endfunction

  task automatic build(input int n, input logic [7:0] tos, input logic [15:0] port,
                       input logic [7:0] proto, input logic [15:0] etype);
    pd.delete();
    ps.delete();
    pkt_seq++;
    for (int i = 0; i < n; i++) begin
      case (i)
        1:       pd.push_back({tos, 8'h45, etype, 32'h0});
        2:       pd.push_back({proto, 56'h40000001000600});
        4:       pd.push_back({16'h4F00, port[7:0], port[15:8], 32'h35000600});
        default: pd.push_back({16'hD00D, 8'(pkt_seq), 8'(i), 32'(i * 32'h01010101 + pkt_seq)});
      endcase
      ps.push_back((i == n - 1) ? 8'h0F : 8'hFF);
    end
  endtask

  task automatic send_pkt(input logic [127:0] tu, input int reset_at, output int stalls);
    bit pass;
    int n, tmo;
    beat_t b;
    pass = model_pass();
    n = pd.size();
    stalls = 0;
    if (pass)
      for (int i = 0; i < n; i++) begin
        b = '{data: pd[i], strb: ps[i], last: (i == n - 1), tuser: tu, op: pbyte(15)};
        exp_q.push_back(b);
      end
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = pd[i];
      s_axis_tstrb  = ps[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tuser  = (i == 0) ? tu : ~tu;
      s_axis_tvalid = 1'b1;
      if (i == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        exp_q.delete();
        m_pass = '0;
        m_drop = '0;
        return;
      end
      tmo = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        stalls++;
        tmo++;
        if (tmo > 200) begin
          n_cmp++;
          n_fail++;
          $display("FAIL ingress_timeout: word %0d still stalled after %0d cycles, expected accept", i, tmo);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (pass) m_pass = sat_inc(m_pass);
    else m_drop = sat_inc(m_drop);
  endtask

  task automatic settle(input string name);
    int tmo = 0;
    while (exp_q.size() != 0 && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_drain: %0d beats still pending, expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
    check({name, "_pass_cnt"}, 256'(pkt_pass_cnt), 256'(m_pass));
    check({name, "_drop_cnt"}, 256'(pkt_drop_cnt), 256'(m_drop));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    m_pass = '0;
    m_drop = '0;
    @(negedge clk);
    check("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("rst_s_tready", 256'(s_axis_tready), 256'(1));
    check("rst_outputs", {m_axis_tlast, m_axis_tdata, m_axis_tstrb, m_axis_tuser}, 256'(0));
    check("rst_counters", {cmd_opcode, pkt_pass_cnt, pkt_drop_cnt}, 256'(0));
    @(posedge clk); #1;
  endtask

  // Egress scoreboard and tvalid-hold check, sampled on the falling edge.
  initial begin
    beat_t cur;
    logic prev_stall;
    logic [63:0] prev_data;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("tvalid_hold", {m_axis_tvalid, m_axis_tdata}, {1'b1, prev_data});
        if (m_axis_tvalid && m_axis_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h, expected no output", m_axis_tdata);
          end else begin
            cur = exp_q.pop_front();
            check("beat", {m_axis_tdata, m_axis_tstrb, m_axis_tlast, m_axis_tuser, cmd_opcode},
                  cur);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, st2, oc;
    logic [127:0] tu;
    tu = {64'hCAFE_F00D_1234_5678, 64'h0BAD_BEEF_0000_0001};
    do_reset();

    // 14-word write packet, tready held high
    rdy_mode = 0;
    build(14, 8'h02, 16'h3039, 8'h11, 16'h0008);
    check("ex_word1", 256'(pd[1]), 256'(64'h0245000800000000));
    check("ex_word4", 256'(pd[4]), 256'(64'h4F00393035000600));
    oc = out_cnt;
    send_pkt(tu, -1, st);
    settle("wr14");
    check("wr14_stall", 256'(st), 256'(5));
    check("wr14_words", 256'(out_cnt - oc), 256'(14));
    check("wr14_opcode", 256'(cmd_opcode), 256'(8'h02));
    check("wr14_pass_lit", 256'(pkt_pass_cnt), 256'(1));

    // 24-word read packet, tready toggling
    rdy_mode = 1;
    build(24, 8'h01, 16'h3039, 8'h11, 16'h0008);
    oc = out_cnt;
    send_pkt(~tu, -1, st);
    settle("rd24");
    check("rd24_words", 256'(out_cnt - oc), 256'(24));
    check("rd24_opcode", 256'(cmd_opcode), 256'(8'h01));

    // wrong port then bad TOS, both dropped without stalling ingress
    rdy_mode = 0;
    do_reset();
    build(10, 8'h02, 16'h3040, 8'h11, 16'h0008);
    send_pkt(tu, -1, st);
    build(10, 8'h03, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, -1, st2);
    settle("bad2");
    check("bad2_stall", 256'(st + st2), 256'(0));
    check("bad2_drop_lit", 256'(pkt_drop_cnt), 256'(2));
    check("bad2_opcode_kept", 256'(cmd_opcode), 256'(0));

    // short packet, then a good write packet
    do_reset();
    build(3, 8'h02, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, -1, st);
    build(9, 8'h02, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, -1, st);
    settle("short");
    check("short_cnt_lit", {pkt_pass_cnt, pkt_drop_cnt}, {16'd1, 16'd1});

    // boundaries: matching 5-word packet dropped, 6-word passes; bad protocol and EtherType
    rdy_mode = 2;
    build(5, 8'h01, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, -1, st);
    build(6, 8'h01, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu ^ 128'h5, -1, st);
    build(8, 8'h02, 16'h3039, 8'h06, 16'h0008);
    send_pkt(tu, -1, st);
    build(8, 8'h02, 16'h3039, 8'h11, 16'h0608);
    send_pkt(tu, -1, st);
    build(17, 8'h02, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu ^ 128'h9, -1, st);
    settle("mix");
    check("mix_cnt_lit", {pkt_pass_cnt, pkt_drop_cnt}, {16'd3, 16'd4});

    // reset while word 8 is in the cut-through phase
    rdy_mode = 0;
    build(14, 8'h02, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, 8, st);
    @(negedge clk);
    check("midrst_state", {m_axis_tvalid, pkt_pass_cnt, pkt_drop_cnt}, 256'(0));
    @(posedge clk); #1;
    build(11, 8'h01, 16'h3039, 8'h11, 16'h0008);
    send_pkt(tu, -1, st);
    settle("after_rst");
    check("after_rst_pass_lit", 256'(pkt_pass_cnt), 256'(1));

    // drop counter saturation
    force dut.drop_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.drop_cnt_q;
    m_drop = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      build(1, 8'h02, 16'h3039, 8'h11, 16'h0008);
      send_pkt(tu, -1, st);
      settle("sat");
    end
    check("sat_lit", 256'(pkt_drop_cnt), 256'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
